// File: rtl/eth_cmd_receiver_if.sv
// Receive-path and command-side signals of the Ethernet command receiver.
// The slave modport is the receiver itself; master is the PHY/control side.
interface eth_cmd_receiver_if;
  logic [7:0]  rx_data;
  logic [1:0]  rx_ctl;
  logic        rx_enable;
  logic        cmd_valid;
  logic        cmd_ack;
  logic [6:0]  cmd_len;
  logic [5:0]  cmd_rd_addr;
  logic [7:0]  cmd_rd_data;
  logic [47:0] src_mac;

  modport master (
    output rx_data, rx_ctl, rx_enable, cmd_ack, cmd_rd_addr,
    input  cmd_valid, cmd_len, cmd_rd_data, src_mac
  );

  modport slave (
    input  rx_data, rx_ctl, rx_enable, cmd_ack, cmd_rd_addr,
    output cmd_valid, cmd_len, cmd_rd_data, src_mac
  );
endinterface

// File: rtl/eth_cmd_receiver.sv
// Parses GMII-style byte frames, CRC-checks command frames addressed to this unit and
// stages up to 64 payload bytes behind a valid/ack handshake with a registered read port.
module eth_cmd_receiver #(
  parameter logic [15:0] ETHERTYPE     = 16'h88B7,
  parameter int unsigned MAX_CMD_BYTES = 64,
  parameter int unsigned MIN_PAYLOAD   = 46,
  parameter int unsigned MAX_PREAMBLE  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [47:0]          i_mac_addr,
  eth_cmd_receiver_if.slave    cmd_if,
  output logic [15:0]          o_good_count,
  output logic [15:0]          o_crc_err_count,
  output logic [15:0]          o_drop_count
);
  typedef enum logic [2:0] {StIdle, StPreamble, StHeader, StPayload, StCheck, StDrop} state_e;

  localparam logic [4:0]  PreMax  = 5'(MAX_PREAMBLE);
  localparam logic [10:0] PayMax  = 11'(MAX_CMD_BYTES);
  localparam logic [10:0] PayMin  = 11'(MIN_PAYLOAD);
  localparam logic [31:0] CrcGood = 32'hDEBB20E3;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_e r_state, w_state_d;
  logic [4:0]       r_pre_cnt, w_pre_cnt_d;
  logic [3:0]       r_hdr_idx, w_hdr_idx_d;
  logic             r_match_local, w_match_local_d, r_match_bcast, w_match_bcast_d;
  logic             r_type_hi_ok, w_type_hi_ok_d;
  logic [47:0]      r_src_shadow, w_src_shadow_d;
  logic [31:0]      r_crc, w_crc_d;
  logic [3:0][7:0]  r_dl, w_dl_d;
  logic [2:0]       r_dl_cnt, w_dl_cnt_d;
  logic [10:0]      r_pay_cnt, w_pay_cnt_d;
  logic             r_busy_at_sfd, w_busy_at_sfd_d;
  logic             r_cmd_valid, w_cmd_valid_d;
  logic [6:0]       r_cmd_len, w_cmd_len_d;
  logic [47:0]      r_src_mac, w_src_mac_d;
  logic [15:0]      r_good, w_good_d, r_crc_err, w_crc_err_d, r_drop, w_drop_d;
  logic [7:0]       r_rd_data;
  logic [7:0]       r_staging [64];

  logic       w_valid, w_idle, w_local, w_bcast, w_frame_ok;
  logic [7:0] w_mac_byte;
  logic       w_wr_en;
  logic [5:0] w_wr_addr;

  assign w_valid = (cmd_if.rx_ctl == 2'b11);
  assign w_idle  = (cmd_if.rx_ctl == 2'b00);

  always_comb begin
    case (r_hdr_idx)
      4'd0:    w_mac_byte = i_mac_addr[47:40];
      4'd1:    w_mac_byte = i_mac_addr[39:32];
      4'd2:    w_mac_byte = i_mac_addr[31:24];
      4'd3:    w_mac_byte = i_mac_addr[23:16];
      4'd4:    w_mac_byte = i_mac_addr[15:8];
      default: w_mac_byte = i_mac_addr[7:0];
    endcase
  end

  // Byte 0 starts a fresh match; later bytes accumulate into the running match flags.
  assign w_local = ((r_hdr_idx == 4'd0) | r_match_local) & (cmd_if.rx_data == w_mac_byte);
  assign w_bcast = ((r_hdr_idx == 4'd0) | r_match_bcast) & (cmd_if.rx_data == 8'hFF);
  assign w_frame_ok = (r_crc == CrcGood) && (r_pay_cnt >= PayMin);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_valid) begin
          w_state_d = (cmd_if.rx_data == 8'h55 && cmd_if.rx_enable) ? StPreamble : StDrop;
        end
      end
      StPreamble: begin
        if (w_valid) begin
          if (cmd_if.rx_data == 8'h55) begin
            if (r_pre_cnt >= PreMax) w_state_d = StDrop;
          end else if (cmd_if.rx_data == 8'hD5) begin
            w_state_d = StHeader;
          end else begin
            w_state_d = StDrop;
          end
        end else begin
          w_state_d = w_idle ? StIdle : StDrop;
        end
      end
      StHeader: begin
        if (!w_valid) begin
          w_state_d = StDrop;
        end else if (r_hdr_idx == 4'd5 && !(w_local || w_bcast)) begin
          w_state_d = StDrop;
        end else if (r_hdr_idx == 4'd13) begin
          w_state_d = (r_type_hi_ok && cmd_if.rx_data == ETHERTYPE[7:0]) ? StPayload : StDrop;
        end
      end
      StPayload: begin
        if (w_idle)        w_state_d = StCheck;
        else if (!w_valid) w_state_d = StDrop;
      end
      StCheck: w_state_d = StIdle;
      StDrop:  if (w_idle) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath next values and staging write strobe
  always_comb begin
    w_pre_cnt_d     = r_pre_cnt;
    w_hdr_idx_d     = r_hdr_idx;
    w_match_local_d = r_match_local;
    w_match_bcast_d = r_match_bcast;
    w_type_hi_ok_d  = r_type_hi_ok;
    w_src_shadow_d  = r_src_shadow;
    w_crc_d         = r_crc;
    w_dl_d          = r_dl;
    w_dl_cnt_d      = r_dl_cnt;
    w_pay_cnt_d     = r_pay_cnt;
    w_busy_at_sfd_d = r_busy_at_sfd;
    w_cmd_valid_d   = r_cmd_valid;
    w_cmd_len_d     = r_cmd_len;
    w_src_mac_d     = r_src_mac;
    w_good_d        = r_good;
    w_crc_err_d     = r_crc_err;
    w_drop_d        = r_drop;
    w_wr_en         = 1'b0;
    w_wr_addr       = r_pay_cnt[5:0];

    if (r_cmd_valid && cmd_if.cmd_ack) w_cmd_valid_d = 1'b0;

    unique case (r_state)
      StIdle: if (w_valid && cmd_if.rx_data == 8'h55 && cmd_if.rx_enable) w_pre_cnt_d = 5'd1;
      StPreamble: begin
        if (w_valid && cmd_if.rx_data == 8'h55) w_pre_cnt_d = r_pre_cnt + 5'd1;
        if (w_valid && cmd_if.rx_data == 8'hD5) begin
          w_crc_d         = 32'hFFFFFFFF;
          w_hdr_idx_d     = 4'd0;
          w_pay_cnt_d     = 11'd0;
          w_dl_cnt_d      = 3'd0;
          w_busy_at_sfd_d = r_cmd_valid;
        end
      end
      StHeader: begin
        if (w_valid) begin
          w_crc_d     = crc_byte(r_crc, cmd_if.rx_data);
          w_hdr_idx_d = r_hdr_idx + 4'd1;
          if (r_hdr_idx <= 4'd5) begin
            w_match_local_d = w_local;
            w_match_bcast_d = w_bcast;
          end else if (r_hdr_idx <= 4'd11) begin
            w_src_shadow_d = {r_src_shadow[39:0], cmd_if.rx_data};
          end else if (r_hdr_idx == 4'd12) begin
            w_type_hi_ok_d = (cmd_if.rx_data == ETHERTYPE[15:8]);
          end
        end
      end
      StPayload: begin
        if (w_valid) begin
          w_crc_d = crc_byte(r_crc, cmd_if.rx_data);
          w_dl_d  = {r_dl[2:0], cmd_if.rx_data};
          // The last four bytes still in the delay line at end of frame are the FCS.
          if (r_dl_cnt == 3'd4) begin
            if (r_pay_cnt != 11'h7FF) w_pay_cnt_d = r_pay_cnt + 11'd1;
            w_wr_en = (r_pay_cnt < PayMax) && !r_busy_at_sfd && !r_cmd_valid;
          end else begin
            w_dl_cnt_d = r_dl_cnt + 3'd1;
          end
        end
      end
      StCheck: begin
        if (w_frame_ok && r_busy_at_sfd) begin
          w_drop_d = r_drop + 16'd1;
        end else if (w_frame_ok) begin
          w_cmd_valid_d = 1'b1;
          w_cmd_len_d   = (r_pay_cnt >= PayMax) ? 7'(MAX_CMD_BYTES) : r_pay_cnt[6:0];
          w_src_mac_d   = r_src_shadow;
          w_good_d      = r_good + 16'd1;
        end else begin
          w_crc_err_d = r_crc_err + 16'd1;
        end
      end
      StDrop:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt     <= '0;
      r_hdr_idx     <= '0;
      r_match_local <= 1'b0;
      r_match_bcast <= 1'b0;
      r_type_hi_ok  <= 1'b0;
      r_src_shadow  <= '0;
      r_crc         <= '0;
      r_dl          <= '0;
      r_dl_cnt      <= '0;
      r_pay_cnt     <= '0;
      r_busy_at_sfd <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_len     <= '0;
      r_src_mac     <= '0;
      r_good        <= '0;
      r_crc_err     <= '0;
      r_drop        <= '0;
      r_rd_data     <= '0;
    end else begin
      r_pre_cnt     <= w_pre_cnt_d;
      r_hdr_idx     <= w_hdr_idx_d;
      r_match_local <= w_match_local_d;
      r_match_bcast <= w_match_bcast_d;
      r_type_hi_ok  <= w_type_hi_ok_d;
      r_src_shadow  <= w_src_shadow_d;
      r_crc         <= w_crc_d;
      r_dl          <= w_dl_d;
      r_dl_cnt      <= w_dl_cnt_d;
      r_pay_cnt     <= w_pay_cnt_d;
      r_busy_at_sfd <= w_busy_at_sfd_d;
      r_cmd_valid   <= w_cmd_valid_d;
      r_cmd_len     <= w_cmd_len_d;
      r_src_mac     <= w_src_mac_d;
      r_good        <= w_good_d;
      r_crc_err     <= w_crc_err_d;
      r_drop        <= w_drop_d;
      r_rd_data     <= r_staging[cmd_if.cmd_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) r_staging[w_wr_addr] <= r_dl[3];
  end

  assign cmd_if.cmd_valid   = r_cmd_valid;
  assign cmd_if.cmd_len     = r_cmd_len;
  assign cmd_if.cmd_rd_data = r_rd_data;
  assign cmd_if.src_mac     = r_src_mac;
  assign o_good_count       = r_good;
  assign o_crc_err_count    = r_crc_err;
  assign o_drop_count       = r_drop;
endmodule

// File: tb/tb_eth_cmd_receiver.sv
// Directed bench for eth_cmd_receiver: builds frames with a reference CRC and checks
// handshake, staging contents and counters against hand-computed values.
module tb_eth_cmd_receiver;
  logic        clk;
  logic        reset;
  logic [47:0] mac;
  logic [15:0] good_cnt, err_cnt, drop_cnt;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  frm[$];
  logic [7:0]  rd;

  localparam logic [47:0] Mac  = 48'h02_11_22_33_44_55;
  localparam logic [47:0] SrcA = 48'hAA_BB_CC_DD_EE_01;
  localparam logic [47:0] SrcB = 48'h66_77_88_99_AA_02;

  eth_cmd_receiver_if cmd_if ();

  eth_cmd_receiver dut (
    .clk             (clk),
    .reset           (reset),
    .i_mac_addr      (mac),
    .cmd_if          (cmd_if),
    .o_good_count    (good_cnt),
    .o_crc_err_count (err_cnt),
    .o_drop_count    (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Payload byte i is i+seed; flip >= 0 inverts bit 0 of that payload byte after FCS.
  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                       input int n, input logic [7:0] seed, input int flip);
    logic [31:0] c;
    int          start;
    frm.delete();
    for (int i = 0; i < 7; i++) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    start = frm.size();
    for (int i = 0; i < 6; i++) frm.push_back(dst[(5 - i) * 8 +: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[(5 - i) * 8 +: 8]);
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int i = 0; i < n; i++) frm.push_back(8'(i) + seed);
    c = 32'hFFFFFFFF;
    for (int j = start; j < frm.size(); j++) c = crc_upd(c, frm[j]);
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
    if (flip >= 0) frm[start + 14 + flip] = frm[start + 14 + flip] ^ 8'h01;
  endtask

  task automatic drive(input logic [1:0] ctl, input logic [7:0] d);
    cmd_if.rx_ctl  = ctl;
    cmd_if.rx_data = d;
    @(negedge clk);
  endtask

  // Sends the first cnt bytes of frm; cnt < 0 sends it all followed by one idle (-> CHECK).
  task automatic send(input int cnt);
    int lim;
    lim = (cnt < 0) ? frm.size() : cnt;
    for (int i = 0; i < lim; i++) drive(2'b11, frm[i]);
    if (cnt < 0) drive(2'b00, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 8'h00);
  endtask

  task automatic read(input logic [5:0] a, output logic [7:0] d);
    cmd_if.cmd_rd_addr = a;
    @(negedge clk);
    d = cmd_if.cmd_rd_data;
  endtask

  task automatic ack();
    cmd_if.cmd_ack = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ack = 1'b0;
  endtask

  initial begin
    mac                = Mac;
    reset              = 1'b1;
    cmd_if.rx_data     = 8'h00;
    cmd_if.rx_ctl      = 2'b00;
    cmd_if.rx_enable   = 1'b1;
    cmd_if.cmd_ack     = 1'b0;
    cmd_if.cmd_rd_addr = 6'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", cmd_if.cmd_valid, 0);
    check("rst_len", cmd_if.cmd_len, 0);
    check("rst_src", cmd_if.src_mac, 0);
    check("rst_rd", cmd_if.cmd_rd_data, 0);
    check("rst_cnts", {good_cnt, err_cnt, drop_cnt}, 0);
    reset = 1'b0;
    idle(2);

    // 1: good unicast command
    build(Mac, SrcA, 16'h88B7, 64, 8'h00, -1);
    send(-1);
    check("t1_valid_early", cmd_if.cmd_valid, 0);
    idle(1);
    check("t1_valid", cmd_if.cmd_valid, 1);
    check("t1_len", cmd_if.cmd_len, 64);
    check("t1_src", cmd_if.src_mac, SrcA);
    check("t1_good", good_cnt, 1);
    read(6'd5, rd);
    check("t1_rd5", rd, 8'h05);
    read(6'd63, rd);
    check("t1_rd63", rd, 8'h3F);
    ack();
    check("t1_ack", cmd_if.cmd_valid, 0);

    // 2: corrupted payload byte
    build(Mac, SrcA, 16'h88B7, 64, 8'h00, 10);
    send(-1);
    idle(2);
    check("t2_valid", cmd_if.cmd_valid, 0);
    check("t2_err", err_cnt, 1);
    check("t2_good", good_cnt, 1);

    // 3: wrong type, wrong dest, and a good frame while disabled
    build(48'hFFFF_FFFF_FFFF, SrcB, 16'h88B5, 64, 8'h00, -1);
    send(-1);
    idle(2);
    build(48'h02_11_22_33_44_66, SrcB, 16'h88B7, 64, 8'h00, -1);
    send(-1);
    idle(2);
    cmd_if.rx_enable = 1'b0;
    build(Mac, SrcB, 16'h88B7, 64, 8'h00, -1);
    send(-1);
    idle(2);
    cmd_if.rx_enable = 1'b1;
    check("t3_cnts", {good_cnt, err_cnt, drop_cnt}, {16'd1, 16'd1, 16'd0});
    check("t3_valid", cmd_if.cmd_valid, 0);
    check("t3_src", cmd_if.src_mac, SrcA);

    // 4: back-to-back without ack, second frame is dropped
    build(48'hFFFF_FFFF_FFFF, SrcB, 16'h88B7, 64, 8'h10, -1);
    send(-1);
    idle(1);
    check("t4_bcast_valid", cmd_if.cmd_valid, 1);
    build(Mac, SrcA, 16'h88B7, 50, 8'h80, -1);
    send(-1);
    idle(2);
    check("t4_drop", drop_cnt, 1);
    check("t4_len", cmd_if.cmd_len, 64);
    check("t4_src", cmd_if.src_mac, SrcB);
    read(6'd7, rd);
    check("t4_rd7", rd, 8'h17);
    ack();
    check("t4_ack", cmd_if.cmd_valid, 0);
    build(Mac, SrcA, 16'h88B7, 64, 8'h40, -1);
    send(-1);
    idle(1);
    check("t4_third_valid", cmd_if.cmd_valid, 1);
    check("t4_good", good_cnt, 3);
    read(6'd7, rd);
    check("t4_rd7_new", rd, 8'h47);
    ack();

    // 5: minimum, oversize and undersize payloads
    build(Mac, SrcA, 16'h88B7, 46, 8'h20, -1);
    send(-1);
    idle(1);
    check("t5_len46", cmd_if.cmd_len, 46);
    read(6'd45, rd);
    check("t5_rd45", rd, 8'h4D);
    ack();
    build(Mac, SrcA, 16'h88B7, 100, 8'h00, -1);
    send(-1);
    idle(1);
    check("t5_len100", cmd_if.cmd_len, 64);
    read(6'd63, rd);
    check("t5_rd63", rd, 8'h3F);
    check("t5_good", good_cnt, 5);
    ack();
    build(Mac, SrcA, 16'h88B7, 40, 8'h00, -1);
    send(-1);
    idle(2);
    check("t5_short_err", err_cnt, 2);
    check("t5_short_valid", cmd_if.cmd_valid, 0);

    // 6: receive error mid-payload, then reset mid-payload
    build(Mac, SrcA, 16'h88B7, 64, 8'h00, -1);
    send(30);
    drive(2'b01, 8'h00);
    drive(2'b11, 8'h12);
    idle(3);
    check("t6_rxerr_cnts", {good_cnt, err_cnt, drop_cnt}, {16'd5, 16'd2, 16'd1});
    check("t6_rxerr_valid", cmd_if.cmd_valid, 0);
    build(Mac, SrcB, 16'h88B7, 64, 8'h00, -1);
    send(40);
    reset = 1'b1;
    idle(2);
    check("t6_rst_cnts", {good_cnt, err_cnt, drop_cnt}, 0);
    check("t6_rst_outs", {cmd_if.cmd_valid, cmd_if.cmd_len, cmd_if.src_mac}, 0);
    check("t6_rst_rd", cmd_if.cmd_rd_data, 0);
    reset = 1'b0;
    idle(2);
    build(Mac, SrcB, 16'h88B7, 64, 8'h33, -1);
    send(-1);
    idle(1);
    check("t6_after_valid", cmd_if.cmd_valid, 1);
    check("t6_after_good", good_cnt, 1);
    check("t6_after_src", cmd_if.src_mac, SrcB);
    read(6'd0, rd);
    check("t6_after_rd0", rd, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
